// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle core control path.
//   state_t       : sequencer state encoding (also driven on the state port)
//   inst_class_t  : decoded instruction class presented by the decoder
//   PC_SEL_*      : next-PC source select codes
//   RD_*          : register-file write-data source select codes
package core_pkg;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_WAIT_IF  = 3'd1,
    S_DECODE   = 3'd2,
    S_EXEC     = 3'd3,
    S_MEM      = 3'd4,
    S_WAIT_MEM = 3'd5,
    S_WB       = 3'd6,
    S_HALT     = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    IC_ALU     = 4'd0,
    IC_LUI     = 4'd1,
    IC_AUIPC   = 4'd2,
    IC_LOAD    = 4'd3,
    IC_STORE   = 4'd4,
    IC_BRANCH  = 4'd5,
    IC_JAL     = 4'd6,
    IC_JALR    = 4'd7,
    IC_SYSTEM  = 4'd8,
    IC_ILLEGAL = 4'd9
  } inst_class_t;

  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_BR   = 2'd1;
  localparam logic [1:0] PC_SEL_JALR = 2'd2;

  localparam logic [1:0] RD_NONE = 2'd0;
  localparam logic [1:0] RD_RES  = 2'd1;
  localparam logic [1:0] RD_MEM  = 2'd2;
  localparam logic [1:0] RD_PC   = 2'd3;

endpackage

// File: rtl/seq_retire_cnt.sv
// Retired-instruction counter.
//   clk, rst : rising-edge clock, synchronous active-high reset (clears count)
//   inc      : add one this cycle
//   cnt      : DW-bit count, wraps from all-ones to zero
module seq_retire_cnt #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [DW-1:0] cnt
);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through
// fetch, decode, execute, memory and write-back, driving datapath enables
// and selects, and counts retired instructions.
//   clk, rst      : rising-edge clock, synchronous active-high reset
//   run           : permits a new fetch
//   inst_class    : decoded class, latched in DECODE
//   br_taken      : branch comparator result, used in EXEC
//   mem_gnt       : memory accepted mem_req this cycle
//   mem_rvalid    : memory read data valid
//   mem_req/mem_we/mem_addr_sel : memory request, write, address source (0 PC, 1 ALU)
//   ir_en, pc_en, pc_sel, rf_en, rd_data_sel : datapath controls
//   state, halted, instret : status
module mc_sequencer
  import core_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic [3:0]    inst_class,
  input  logic          br_taken,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  output logic          mem_req,
  output logic          mem_we,
  output logic          mem_addr_sel,
  output logic          ir_en,
  output logic          pc_en,
  output logic [1:0]    pc_sel,
  output logic          rf_en,
  output logic [1:0]    rd_data_sel,
  output logic [2:0]    state,
  output logic          halted,
  output logic [DW-1:0] instret
);

  // The PC mux must at least hold a word-aligned address.
  if (AW < 2) begin : g_aw_chk
    $error("mc_sequencer: AW too small for PC mux");
  end

  state_t      state_q, state_d;
  inst_class_t cls_q, cls_d;

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_en        = 1'b0;
    pc_en        = 1'b0;
    pc_sel       = PC_SEL_PC4;
    rf_en        = 1'b0;
    rd_data_sel  = RD_NONE;

    case (state_q)
      S_FETCH: begin
        if (run) begin
          mem_req = 1'b1;
          if (mem_gnt) state_d = S_WAIT_IF;
        end
      end
      S_WAIT_IF: begin
        if (mem_rvalid) begin
          ir_en   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = inst_class_t'(inst_class);
        case (inst_class_t'(inst_class))
          IC_ALU, IC_LUI, IC_AUIPC, IC_LOAD, IC_STORE,
          IC_BRANCH, IC_JAL, IC_JALR: state_d = S_EXEC;
          // SYSTEM, ILLEGAL and undefined codes all stop the core
          default:                    state_d = S_HALT;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          IC_ALU, IC_LUI, IC_AUIPC, IC_JAL, IC_JALR: state_d = S_WB;
          IC_LOAD, IC_STORE:                         state_d = S_MEM;
          IC_BRANCH: begin
            pc_en   = 1'b1;
            pc_sel  = br_taken ? PC_SEL_BR : PC_SEL_PC4;
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == IC_STORE);
        if (mem_gnt) begin
          if (cls_q == IC_STORE) begin
            pc_en   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WAIT_MEM;
          end
        end
      end
      S_WAIT_MEM: begin
        if (mem_rvalid) state_d = S_WB;
      end
      S_WB: begin
        rf_en   = 1'b1;
        pc_en   = 1'b1;
        state_d = S_FETCH;
        case (cls_q)
          IC_LOAD: rd_data_sel = RD_MEM;
          IC_JAL: begin
            rd_data_sel = RD_PC;
            pc_sel      = PC_SEL_BR;
          end
          IC_JALR: begin
            rd_data_sel = RD_PC;
            pc_sel      = PC_SEL_JALR;
          end
          default: rd_data_sel = RD_RES;
        endcase
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cls_q   <= IC_ALU;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  assign state  = state_q;
  assign halted = (state_q == S_HALT);

  seq_retire_cnt #(.DW(DW)) u_retire (
    .clk (clk),
    .rst (rst),
    .inc (pc_en),
    .cnt (instret)
  );

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed testbench for mc_sequencer. Inputs change 1 ns after each rising
// edge; outputs are checked 1 ns later, well before the next edge.
module tb_mc_sequencer;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [3:0]  inst_class;
  logic        br_taken;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic        mem_req, mem_we, mem_addr_sel, ir_en, pc_en, rf_en, halted;
  logic [1:0]  pc_sel, rd_data_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mc_sequencer #(.AW(32), .DW(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .inst_class   (inst_class),
    .br_taken     (br_taken),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr_sel (mem_addr_sel),
    .ir_en        (ir_en),
    .pc_en        (pc_en),
    .pc_sel       (pc_sel),
    .rf_en        (rf_en),
    .rd_data_sel  (rd_data_sel),
    .state        (state),
    .halted       (halted),
    .instret      (instret)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FETCH (gnt same cycle) -> WAIT_IF (rvalid) -> DECODE with class cls.
  // Returns one cycle after DECODE with inst_class scrambled to ILLEGAL so
  // a sequencer that fails to latch the class would misbehave.
  task automatic do_fetch(input logic [3:0] cls, input string tag);
    run = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b0;
    #1;
    chk({tag, "_fetch_state"}, 32'(state), 32'(S_FETCH));
    chk({tag, "_fetch_req"}, 32'(mem_req), 32'd1);
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1;
    #1;
    chk({tag, "_ir_en"}, 32'(ir_en), 32'd1);
    tick();
    mem_rvalid = 1'b0; inst_class = cls;
    #1;
    chk({tag, "_decode_state"}, 32'(state), 32'(S_DECODE));
    tick();
    inst_class = 4'(IC_ILLEGAL);
  endtask

  task automatic run_alu(input string tag);
    do_fetch(4'(IC_ALU), tag);
    tick();  // EXEC -> WB
    tick();  // WB -> FETCH
  endtask

  initial begin
    logic any_req;
    rst = 1'b1; run = 1'b0; inst_class = 4'(IC_ALU); br_taken = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(S_FETCH));
    chk("rst_instret", instret, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_req_run0", 32'(mem_req), 32'd0);
    chk("rst_pc_sel", 32'(pc_sel), 32'(PC_SEL_PC4));
    // gnt while no request is ignored
    mem_gnt = 1'b1;
    tick();
    chk("gnt_no_req_state", 32'(state), 32'(S_FETCH));
    mem_gnt = 1'b0;

    // ALU: ir_en cycle 2, rf_en+pc_en cycle 5, PC4, instret 0->1
    do_fetch(4'(IC_ALU), "alu");
    chk("alu_exec_state", 32'(state), 32'(S_EXEC));
    chk("alu_exec_pc_en", 32'(pc_en), 32'd0);
    tick();
    chk("alu_wb_rf_en", 32'(rf_en), 32'd1);
    chk("alu_wb_pc_en", 32'(pc_en), 32'd1);
    chk("alu_wb_pc_sel", 32'(pc_sel), 32'(PC_SEL_PC4));
    chk("alu_wb_rd_sel", 32'(rd_data_sel), 32'(RD_RES));
    chk("alu_instret_before", instret, 32'd0);
    tick();
    chk("alu_back_fetch", 32'(state), 32'(S_FETCH));
    chk("alu_instret_after", instret, 32'd1);

    // LOAD with gnt held off 3 cycles in MEM
    do_fetch(4'(IC_LOAD), "ld");
    tick();
    for (int i = 0; i < 4; i++) begin
      mem_gnt = (i == 3);
      #1;
      chk("ld_mem_req", 32'(mem_req), 32'd1);
      chk("ld_mem_we", 32'(mem_we), 32'd0);
      chk("ld_addr_sel", 32'(mem_addr_sel), 32'd1);
      tick();
    end
    mem_gnt = 1'b0;
    chk("ld_wait_mem", 32'(state), 32'(S_WAIT_MEM));
    chk("ld_wait_no_req", 32'(mem_req), 32'd0);
    tick();
    chk("ld_wait_mem_hold", 32'(state), 32'(S_WAIT_MEM));
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    #1;
    chk("ld_wb_rf_en", 32'(rf_en), 32'd1);
    chk("ld_wb_rd_sel", 32'(rd_data_sel), 32'(RD_MEM));
    chk("ld_wb_pc_sel", 32'(pc_sel), 32'(PC_SEL_PC4));
    tick();
    chk("ld_instret", instret, 32'd2);

    // STORE
    do_fetch(4'(IC_STORE), "st");
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("st_mem_we", 32'(mem_we), 32'd1);
    chk("st_pc_en", 32'(pc_en), 32'd1);
    chk("st_rf_en", 32'(rf_en), 32'd0);
    tick();
    mem_gnt = 1'b0;
    chk("st_back_fetch", 32'(state), 32'(S_FETCH));
    chk("st_instret", instret, 32'd3);

    // BRANCH taken then not taken
    do_fetch(4'(IC_BRANCH), "br1");
    br_taken = 1'b1;
    #1;
    chk("br1_pc_en", 32'(pc_en), 32'd1);
    chk("br1_pc_sel", 32'(pc_sel), 32'(PC_SEL_BR));
    chk("br1_rf_en", 32'(rf_en), 32'd0);
    tick();
    chk("br1_fetch", 32'(state), 32'(S_FETCH));
    do_fetch(4'(IC_BRANCH), "br0");
    br_taken = 1'b0;
    #1;
    chk("br0_pc_en", 32'(pc_en), 32'd1);
    chk("br0_pc_sel", 32'(pc_sel), 32'(PC_SEL_PC4));
    chk("br0_rf_en", 32'(rf_en), 32'd0);
    tick();
    chk("br_instret", instret, 32'd5);

    // JALR and JAL write-back selects
    do_fetch(4'(IC_JALR), "jalr");
    tick();
    chk("jalr_rd_sel", 32'(rd_data_sel), 32'(RD_PC));
    chk("jalr_pc_sel", 32'(pc_sel), 32'(PC_SEL_JALR));
    tick();
    do_fetch(4'(IC_JAL), "jal");
    tick();
    chk("jal_rd_sel", 32'(rd_data_sel), 32'(RD_PC));
    chk("jal_pc_sel", 32'(pc_sel), 32'(PC_SEL_BR));
    tick();
    chk("jal_instret", instret, 32'd7);

    // instret wrap
    dut.u_retire.cnt_q = 32'hFFFF_FFFE;
    run_alu("wrap1");
    chk("wrap_ffffffff", instret, 32'hFFFF_FFFF);
    run_alu("wrap2");
    chk("wrap_zero", instret, 32'h0000_0000);

    // reset in WAIT_MEM with a stray rvalid afterwards
    run_alu("pre_rst");
    do_fetch(4'(IC_LOAD), "rld");
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rld_wait_mem", 32'(state), 32'(S_WAIT_MEM));
    rst = 1'b1;
    tick();
    rst = 1'b0; run = 1'b0; mem_rvalid = 1'b1;
    #1;
    chk("rld_state", 32'(state), 32'(S_FETCH));
    chk("rld_rf_en", 32'(rf_en), 32'd0);
    chk("rld_ir_en", 32'(ir_en), 32'd0);
    chk("rld_instret", instret, 32'd0);
    tick();
    run = 1'b1;
    #1;
    chk("rld_stray_ir_en", 32'(ir_en), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    chk("rld_stray_state", 32'(state), 32'(S_FETCH));

    // ILLEGAL -> HALT
    do_fetch(4'(IC_ILLEGAL), "ill");
    chk("ill_state", 32'(state), 32'(S_HALT));
    chk("ill_halted", 32'(halted), 32'd1);
    any_req = 1'b0;
    run = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      any_req = any_req | mem_req | pc_en | rf_en | ir_en;
      tick();
    end
    chk("ill_no_outputs", 32'(any_req), 32'd0);
    chk("ill_still_halt", 32'(state), 32'(S_HALT));
    rst = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("ill_rst_state", 32'(state), 32'(S_FETCH));
    chk("ill_rst_halted", 32'(halted), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
